pitchwheel_interp_mc: RTL and testbench

PITCHWHEEL_INTERP_MC -- requirements
Module: pitchwheel_interp_mc

---
 rtl/pitchwheel_interp_mc.sv | 160 ++++++++++++++++
 tb/tb_pitchwheel_interp_mc.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pitchwheel_interp_mc.sv
// Multi-channel pitch-wheel interpolator: per-channel PW registers feed a
// five-state sequencer that reads two table words and blends them linearly.
module pitchwheel_interp_mc #(
  parameter int NCH      = 16,
  parameter int PW_W     = 14,
  parameter int SEG_BITS = 4,
  parameter int TBL_W    = 17,
  parameter int OUT_W    = 18,
  parameter int ROUND    = 1,
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pw_wr,
  input  logic [CH_W-1:0]     pw_ch,
  input  logic [PW_W-1:0]     pw_val,
  input  logic                req,
  input  logic [CH_W-1:0]     req_ch,
  input  logic                auto_scan,
  output logic                ready,
  output logic [SEG_BITS:0]   tbl_addr,
  input  logic [TBL_W-1:0]    tbl_data,
  output logic                out_valid,
  output logic [CH_W-1:0]     out_ch,
  output logic [OUT_W-1:0]    data_out
);

  localparam int F      = PW_W - SEG_BITS;
  localparam int A_W    = SEG_BITS + 1;
  localparam int PROD_W = (TBL_W + F + 2 > OUT_W + 2) ? (TBL_W + F + 2) : (OUT_W + 2);
  localparam logic [PW_W-1:0] PW_CENTRE = {1'b1, {(PW_W-1){1'b0}}};
  localparam logic signed [PROD_W-1:0] RND = (ROUND != 0) ? (PROD_W'(1) << (F-1)) : '0;
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'({OUT_W{1'b1}});

  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_MUL, S_OUT} state_t;

  state_t                state_q, state_d;
  logic [PW_W-1:0]       pw_regs_q [NCH];
  logic [PW_W-1:0]       pw_regs_d [NCH];
  logic                  ready_q, ready_d;
  logic [A_W-1:0]        tbl_addr_q, tbl_addr_d;
  logic [CH_W-1:0]       scan_ptr_q, scan_ptr_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [PW_W-1:0]       snap_q, snap_d;
  logic [TBL_W-1:0]      lo_q, lo_d, hi_q, hi_d;
  logic                  out_valid_q, out_valid_d;
  logic [CH_W-1:0]       out_ch_q, out_ch_d;
  logic [OUT_W-1:0]      data_out_q, data_out_d;

  logic [CH_W-1:0]          sel_ch;
  logic [F-1:0]             frac;
  logic signed [TBL_W:0]    diff;
  logic signed [PROD_W-1:0] prod, prod_sh, sum_s;
  logic [OUT_W-1:0]         sat_res;

  // Arithmetic shift floors, so descending pairs round toward the upper entry consistently.
  always_comb begin
    frac    = snap_q[F-1:0];
    diff    = $signed({1'b0, hi_q}) - $signed({1'b0, lo_q});
    prod    = PROD_W'(diff) * PROD_W'($signed({1'b0, frac}));
    prod_sh = (prod + RND) >>> F;
    sum_s   = PROD_W'($signed({1'b0, lo_q})) + prod_sh;
    if (sum_s < 0)            sat_res = '0;
    else if (sum_s > SAT_MAX) sat_res = {OUT_W{1'b1}};
    else                      sat_res = OUT_W'(sum_s);
  end

  always_comb begin
    state_d     = state_q;
    pw_regs_d   = pw_regs_q;
    ready_d     = ready_q;
    tbl_addr_d  = '0;
    scan_ptr_d  = scan_ptr_q;
    ch_d        = ch_q;
    snap_d      = snap_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    data_out_d  = data_out_q;
    sel_ch      = req ? req_ch : scan_ptr_q;

    if (pw_wr && (32'(pw_ch) < NCH)) pw_regs_d[pw_ch] = pw_val;

    case (state_q)
      S_IDLE: begin
        if (req || auto_scan) begin
          // Snapshot reads the old register, so a same-cycle write lands for the next request.
          ch_d       = sel_ch;
          snap_d     = pw_regs_q[sel_ch];
          tbl_addr_d = A_W'(pw_regs_q[sel_ch][PW_W-1 -: SEG_BITS]);
          state_d    = S_LO;
          ready_d    = 1'b0;
          if (!req)
            scan_ptr_d = (scan_ptr_q == CH_W'(NCH-1)) ? '0 : scan_ptr_q + CH_W'(1);
        end
      end
      S_LO: begin
        tbl_addr_d = A_W'(snap_q[PW_W-1 -: SEG_BITS]) + A_W'(1);
        state_d    = S_HI;
      end
      S_HI: begin
        lo_d    = tbl_data;
        state_d = S_MUL;
      end
      S_MUL: begin
        hi_d    = tbl_data;
        state_d = S_OUT;
      end
      S_OUT: begin
        data_out_d  = sat_res;
        out_ch_d    = ch_q;
        out_valid_d = 1'b1;
        ready_d     = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < NCH; i++) pw_regs_q[i] <= PW_CENTRE;
      ready_q     <= 1'b1;
      tbl_addr_q  <= '0;
      scan_ptr_q  <= '0;
      ch_q        <= '0;
      snap_q      <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      pw_regs_q   <= pw_regs_d;
      ready_q     <= ready_d;
      tbl_addr_q  <= tbl_addr_d;
      scan_ptr_q  <= scan_ptr_d;
      ch_q        <= ch_d;
      snap_q      <= snap_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      data_out_q  <= data_out_d;
    end
  end

  assign ready     = ready_q;
  assign tbl_addr  = tbl_addr_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_pitchwheel_interp_mc.sv
// Directed bench for pitchwheel_interp_mc: a rounding and a truncating instance
// share stimulus; each has its own synchronous table model T[k]=1000*k.
module tb_pitchwheel_interp_mc;

  logic        clk = 1'b0;
  logic        reset, pw_wr, req, auto_scan;
  logic [3:0]  pw_ch, req_ch;
  logic [13:0] pw_val;
  logic        desc_mode;

  logic        ready_a, ready_b, out_valid_a, out_valid_b;
  logic [4:0]  tbl_addr_a, tbl_addr_b;
  logic [16:0] tbl_data_a, tbl_data_b;
  logic [3:0]  out_ch_a, out_ch_b;
  logic [17:0] data_out_a, data_out_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pitchwheel_interp_mc #(.ROUND(1)) dut_a (
    .clk(clk), .reset(reset), .pw_wr(pw_wr), .pw_ch(pw_ch), .pw_val(pw_val),
    .req(req), .req_ch(req_ch), .auto_scan(auto_scan), .ready(ready_a),
    .tbl_addr(tbl_addr_a), .tbl_data(tbl_data_a), .out_valid(out_valid_a),
    .out_ch(out_ch_a), .data_out(data_out_a)
  );

  pitchwheel_interp_mc #(.ROUND(0)) dut_b (
    .clk(clk), .reset(reset), .pw_wr(pw_wr), .pw_ch(pw_ch), .pw_val(pw_val),
    .req(req), .req_ch(req_ch), .auto_scan(auto_scan), .ready(ready_b),
    .tbl_addr(tbl_addr_b), .tbl_data(tbl_data_b), .out_valid(out_valid_b),
    .out_ch(out_ch_b), .data_out(data_out_b)
  );

  function automatic logic [16:0] tbl_val(input logic [4:0] a);
    if (desc_mode && a == 5'd8) return 17'd9000;
    if (desc_mode && a == 5'd9) return 17'd8000;
    return 17'(32'(a) * 1000);
  endfunction

  always @(posedge clk) begin
    tbl_data_a <= tbl_val(tbl_addr_a);
    tbl_data_b <= tbl_val(tbl_addr_b);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", ready_a, 1);
  endtask

  task automatic wait_valid(output int at);
    int n = 0;
    @(negedge clk);
    while (!out_valid_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("valid_wait", out_valid_a, 1);
    at = cyc;
  endtask

  task automatic write_pw(input logic [3:0] ch, input logic [13:0] v);
    pw_wr = 1'b1; pw_ch = ch; pw_val = v;
    @(negedge clk);
    pw_wr = 1'b0;
  endtask

  // One full request; optional pw_wr to the same channel on the accepting edge.
  task automatic do_req(input logic [3:0] ch, input bit wr, input logic [13:0] wv,
                        input int exp_idx, input int exp_a, input int exp_b);
    wait_ready();
    req = 1'b1; req_ch = ch;
    if (wr) begin pw_wr = 1'b1; pw_ch = ch; pw_val = wv; end
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; pw_wr = 1'b0;
    chk("lo_addr", tbl_addr_a, exp_idx);
    chk("busy_ready", ready_a, 0);
    @(negedge clk);
    chk("hi_addr", tbl_addr_a, exp_idx + 1);
    @(negedge clk);
    chk("mul_addr", tbl_addr_a, 0);
    chk("mul_novalid", out_valid_a, 0);
    @(negedge clk);
    chk("out_novalid", out_valid_a, 0);
    @(negedge clk);
    chk("valid_a", out_valid_a, 1);
    chk("valid_b", out_valid_b, 1);
    chk("data_a", data_out_a, exp_a);
    chk("data_b", data_out_b, exp_b);
    chk("out_ch_a", out_ch_a, ch);
    chk("out_ch_b", out_ch_b, ch);
    chk("ready_back", ready_a, 1);
    @(negedge clk);
    chk("valid_drop", out_valid_a, 0);
    chk("data_hold", data_out_a, exp_a);
    chk("ch_hold", out_ch_a, ch);
  endtask

  task automatic chk_reset_state();
    chk("rst_ready_a", ready_a, 1);
    chk("rst_ready_b", ready_b, 1);
    chk("rst_valid", out_valid_a, 0);
    chk("rst_out_ch", out_ch_a, 0);
    chk("rst_data", data_out_a, 0);
    chk("rst_addr", tbl_addr_a, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, prev, t_first, seen;
    reset = 1'b1; pw_wr = 1'b0; pw_ch = '0; pw_val = '0;
    req = 1'b0; req_ch = '0; auto_scan = 1'b0; desc_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state();
    reset = 1'b0;
    @(negedge clk);

    // centre, interpolation, rounding, top end
    do_req(4'd3, 1'b0, '0, 8, 8000, 8000);
    write_pw(4'd5, 14'h2200);
    do_req(4'd5, 1'b0, '0, 8, 8500, 8500);
    write_pw(4'd5, 14'h2001);
    do_req(4'd5, 1'b0, '0, 8, 8001, 8000);
    write_pw(4'd7, 14'h3FFF);
    do_req(4'd7, 1'b0, '0, 15, 15999, 15999);

    // descending pair T[8]=9000, T[9]=8000
    desc_mode = 1'b1;
    write_pw(4'd5, 14'h2200);
    do_req(4'd5, 1'b0, '0, 8, 8500, 8500);
    write_pw(4'd5, 14'h2100);
    do_req(4'd5, 1'b0, '0, 8, 8750, 8750);
    desc_mode = 1'b0;

    // same-cycle write and accept on ch 2: old value used, new value next time
    do_req(4'd2, 1'b1, 14'h2200, 8, 8000, 8000);
    do_req(4'd2, 1'b0, '0, 8, 8500, 8500);

    // req held through a busy period
    write_pw(4'd5, 14'h2200);
    wait_ready();
    req = 1'b1; req_ch = 4'd5;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("held_busy_ready", ready_a, 0);
      chk("held_busy_valid", out_valid_a, 0);
    end
    @(negedge clk);
    chk("held_first_valid", out_valid_a, 1);
    chk("held_first_data", data_out_a, 8500);
    chk("held_ready_idle", ready_a, 1);
    t_first = cyc;
    @(negedge clk);
    chk("held_accepted", ready_a, 0);
    chk("held_lo_addr", tbl_addr_a, 8);
    req = 1'b0;
    wait_valid(at);
    chk("held_gap", at - t_first, 5);
    chk("held_second_data", data_out_a, 8500);

    // round-robin scan, then an external request slotted in
    @(negedge clk);
    auto_scan = 1'b1;
    prev = 0;
    for (int k = 0; k < 17; k++) begin
      wait_valid(at);
      chk("scan_ch", out_ch_a, k % 16);
      if (k > 0) chk("scan_gap", at - prev, 5);
      prev = at;
    end
    req = 1'b1; req_ch = 4'd9;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    wait_valid(at);
    chk("ext_ch", out_ch_a, 9);
    chk("ext_gap", at - prev, 5);
    wait_valid(at);
    chk("resume_ch1", out_ch_a, 1);
    wait_valid(at);
    chk("resume_ch2", out_ch_a, 2);
    auto_scan = 1'b0;
    @(negedge clk);

    // reset during HI
    wait_ready();
    req = 1'b1; req_ch = 4'd4;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state();
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid_a) seen++;
    end
    chk("rst_no_pulse", seen, 0);
    chk("rst_ready_after", ready_a, 1);
    auto_scan = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wait_valid(at);
      chk("rst_scan_ch", out_ch_a, k);
      chk("rst_centre", data_out_a, 8000);
    end
    auto_scan = 1'b0;
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
